id_stage: RTL

Pipelined instruction-decode stage for the OpenMIPS core: decodes the IF/ID instruction, reads and forwards register operands, resolves beq/bne/j in ID, and drives a registered ID/EX pipeline register. It generalises the combinational decoder with parametrised data width, sign-extended immediates, load-use interlock with bubble insertion, branch flush, register-0 protection and an illegal-instruction flag. It sits between the IF/ID register and the EX stage and feeds stall/flush back to PC/IF.

---
 rtl/id_stage.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// OpenMIPS instruction-decode stage: operand select, load-use interlock, beq/bne/j resolved in ID,
// registered ID/EX outputs. Optional macro ID_FWD_EN enables the EX/MEM forwarding paths.
module id_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [31:0]       inst_i,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_load_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  output logic              stall_o,
  output logic              branch_o,
  output logic [DATA_W-1:0] pc_o,
  output logic              flush_o,
  output logic              ex_valid_o,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              alusrc_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic              memW_o,
  output logic              memR_o,
  output logic              in_o,
  output logic              out_o,
  output logic              illegal_o
);

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpSw      = 6'h2B;
  localparam logic [5:0] OpLwIo    = 6'h30;
  localparam logic [5:0] OpSwIo    = 6'h31;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [7:0] AluNop = 8'h00;
  localparam logic [7:0] AluAdd = 8'h20;
  localparam logic [7:0] AluSub = 8'h22;
  localparam logic [7:0] AluAnd = 8'h24;
  localparam logic [7:0] AluOr  = 8'h25;
  localparam logic [7:0] AluSlt = 8'h2A;
  localparam logic [7:0] AluLw  = 8'hE3;
  localparam logic [7:0] AluSw  = 8'hEB;

  localparam logic [2:0] SelNop   = 3'b000;
  localparam logic [2:0] SelLogic = 3'b001;
  localparam logic [2:0] SelArith = 3'b100;
  localparam logic [2:0] SelLdSt  = 3'b111;

  logic [5:0]        op, funct;
  logic [4:0]        sa;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] sext_imm, pc_plus4, br_target, j_target;

  assign op       = inst_i[31:26];
  assign funct    = inst_i[5:0];
  assign sa       = inst_i[10:6];
  assign rs       = REG_AW'(inst_i[25:21]);
  assign rt       = REG_AW'(inst_i[20:16]);
  assign rd       = REG_AW'(inst_i[15:11]);
  assign sext_imm = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};
  assign pc_plus4 = pc_i + DATA_W'(4);
  assign br_target = pc_plus4 + {sext_imm[DATA_W-3:0], 2'b00};
  assign j_target  = {pc_plus4[DATA_W-1:28], inst_i[25:0], 2'b00};

  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic              need_rs, need_rt, dec_wreg, dec_alusrc, dec_memw, dec_memr;
  logic              dec_in, dec_out, dec_illegal, is_beq, is_bne, is_j;
  logic [REG_AW-1:0] dec_wd;
  logic [DATA_W-1:0] dec_imm;

  always_comb begin
    dec_aluop   = AluNop;
    dec_alusel  = SelNop;
    need_rs     = 1'b0;
    need_rt     = 1'b0;
    dec_wreg    = 1'b0;
    dec_wd      = '0;
    dec_alusrc  = 1'b0;
    dec_memw    = 1'b0;
    dec_memr    = 1'b0;
    dec_in      = 1'b0;
    dec_out     = 1'b0;
    dec_illegal = 1'b0;
    dec_imm     = '0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    is_j        = 1'b0;
    case (op)
      OpSpecial: begin
        if (sa != 5'd0) begin
          dec_illegal = 1'b1;
        end else begin
          case (funct)
            FnAdd:   begin dec_aluop = AluAdd; dec_alusel = SelArith; end
            FnSub:   begin dec_aluop = AluSub; dec_alusel = SelArith; end
            FnAnd:   begin dec_aluop = AluAnd; dec_alusel = SelLogic; end
            FnOr:    begin dec_aluop = AluOr;  dec_alusel = SelLogic; end
            FnSlt:   begin dec_aluop = AluSlt; dec_alusel = SelArith; end
            default: dec_illegal = 1'b1;
          endcase
          if (!dec_illegal) begin
            need_rs  = 1'b1;
            need_rt  = 1'b1;
            dec_wreg = 1'b1;
            dec_wd   = rd;
          end
        end
      end
      OpLw, OpLwIo: begin
        dec_aluop  = AluLw;
        dec_alusel = SelLdSt;
        need_rs    = 1'b1;
        dec_wreg   = 1'b1;
        dec_wd     = rt;
        dec_alusrc = 1'b1;
        dec_imm    = sext_imm;
        dec_memr   = (op == OpLw);
        dec_in     = (op == OpLwIo);
      end
      OpSw, OpSwIo: begin
        dec_aluop  = AluSw;
        dec_alusel = SelLdSt;
        need_rs    = 1'b1;
        need_rt    = 1'b1;
        dec_alusrc = 1'b1;
        dec_imm    = sext_imm;
        dec_memw   = (op == OpSw);
        dec_out    = (op == OpSwIo);
      end
      OpBeq, OpBne: begin
        need_rs = 1'b1;
        need_rt = 1'b1;
        dec_imm = sext_imm;
        is_beq  = (op == OpBeq);
        is_bne  = (op == OpBne);
      end
      OpJ:     is_j = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  assign reg1_read_o = id_valid_i & need_rs;
  assign reg2_read_o = id_valid_i & need_rt;
  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;

  logic              ex_hit1, ex_hit2, mem_hit1, mem_hit2, haz1, haz2;
  logic [DATA_W-1:0] op1, op2;

  assign ex_hit1  = ex_wreg_i && (ex_wd_i == rs);
  assign ex_hit2  = ex_wreg_i && (ex_wd_i == rt);
  assign mem_hit1 = mem_wreg_i && (mem_wd_i == rs);
  assign mem_hit2 = mem_wreg_i && (mem_wd_i == rt);

`ifdef ID_FWD_EN
  // EX has priority over MEM: it holds the younger write to the same register.
  assign op1 = (!reg1_read_o || rs == '0) ? '0 :
               ex_hit1 ? ex_wdata_i : mem_hit1 ? mem_wdata_i : reg1_data_i;
  assign op2 = (!reg2_read_o || rt == '0) ? '0 :
               ex_hit2 ? ex_wdata_i : mem_hit2 ? mem_wdata_i : reg2_data_i;
  assign haz1 = reg1_read_o && (rs != '0) && ex_hit1 && ex_load_i;
  assign haz2 = reg2_read_o && (rt != '0) && ex_hit2 && ex_load_i;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_wdata_i, mem_wdata_i, ex_load_i};

  // Without forwarding, wait until every in-flight writer has retired to the regfile.
  assign op1  = (!reg1_read_o || rs == '0) ? '0 : reg1_data_i;
  assign op2  = (!reg2_read_o || rt == '0) ? '0 : reg2_data_i;
  assign haz1 = reg1_read_o && (rs != '0) && (ex_hit1 || mem_hit1);
  assign haz2 = reg2_read_o && (rt != '0) && (ex_hit2 || mem_hit2);
`endif

  logic issue, taken;

  assign stall_o  = haz1 | haz2;
  assign issue    = id_valid_i & ~stall_o;
  assign taken    = issue & ((is_beq & (op1 == op2)) | (is_bne & (op1 != op2)) | is_j);
  assign branch_o = taken;
  assign flush_o  = taken;
  assign pc_o     = !taken ? '0 : is_j ? j_target : br_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_o <= 1'b0;
      aluop_o    <= '0;
      alusel_o   <= '0;
      reg1_o     <= '0;
      reg2_o     <= '0;
      imm_o      <= '0;
      alusrc_o   <= 1'b0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      memW_o     <= 1'b0;
      memR_o     <= 1'b0;
      in_o       <= 1'b0;
      out_o      <= 1'b0;
      illegal_o  <= 1'b0;
    end else begin
      ex_valid_o <= issue;
      aluop_o    <= issue ? dec_aluop  : '0;
      alusel_o   <= issue ? dec_alusel : '0;
      reg1_o     <= issue ? op1        : '0;
      reg2_o     <= issue ? op2        : '0;
      imm_o      <= issue ? dec_imm    : '0;
      alusrc_o   <= issue & dec_alusrc;
      wd_o       <= issue ? dec_wd     : '0;
      wreg_o     <= issue & dec_wreg;
      memW_o     <= issue & dec_memw;
      memR_o     <= issue & dec_memr;
      in_o       <= issue & dec_in;
      out_o      <= issue & dec_out;
      illegal_o  <= issue & dec_illegal;
    end
  end

endmodule
